// File: rtl/mips_fetch_unit_pkg.sv
// Shared types and constants for the MIPS instruction-fetch front end.
package mips_fetch_unit_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    DRAIN = 2'd1,
    STALL = 2'd2
  } fetchState_e;

  localparam logic [31:0] PC_INC          = 32'd4;
  localparam logic [31:0] ADDR_ALIGN_MASK = 32'hFFFF_FFFC;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetchEntry_t;

  function automatic logic [31:0] alignPc(input logic [31:0] addr);
    return addr & ADDR_ALIGN_MASK;
  endfunction

endpackage

// File: rtl/mips_fetch_unit_if.sv
// Instruction-memory, IR-delivery and redirect signals between the fetch unit and its neighbours.
interface mips_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        ir_valid;
  logic [31:0] ir_out;
  logic [31:0] ir_pc;
  logic        ir_ready;
  logic        redirect;
  logic [31:0] redirect_pc;

  modport master (
    output imem_req, imem_addr, ir_valid, ir_out, ir_pc,
    input  imem_ack, imem_rdata, ir_ready, redirect, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, ir_valid, ir_out, ir_pc,
    output imem_ack, imem_rdata, ir_ready, redirect, redirect_pc
  );
endinterface

// File: rtl/mips_fetch_unit_fetch_buffer.sv
// Synchronous FIFO of {pc, instr} entries with flush; head is presented as zero while empty.
module mips_fetch_unit_fetch_buffer
  import mips_fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  fetchEntry_t   pushEntry,
  input  logic          pop,
  input  logic          flush,
  output logic          headValid,
  output fetchEntry_t   headEntry,
  output logic [CW-1:0] count
);

  fetchEntry_t   mem [DEPTH];
  logic [AW-1:0] rdPtr;
  logic [AW-1:0] wrPtr;
  logic          doPush;
  logic          doPop;

  // Flush wins over both push and pop issued in the same cycle.
  assign doPush    = push && !flush;
  assign doPop     = pop && headValid && !flush;
  assign headValid = (count != '0);
  assign headEntry = headValid ? mem[rdPtr] : '0;

  // NOTE: the storage array has no reset; count gates every read, so stale contents are never visible.
  always_ff @(posedge clk) begin
    if (doPush) begin
      mem[wrPtr] <= pushEntry;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + AW'(1);
      if (doPop)  rdPtr <= rdPtr + AW'(1);
      count <= count + CW'(doPush) - CW'(doPop);
    end
  end

endmodule

// File: rtl/mips_fetch_unit.sv
// Fetch front end: owns the fetch PC, talks req/ack to instruction memory, buffers words for the datapath.
module mips_fetch_unit
  import mips_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic               clk,
  input  logic               reset,
  mips_fetch_unit_if.master  bus,
  output logic [31:0]        pc_out
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetchState_e   state;
  fetchState_e   stateNext;
  logic [31:0]   fetchPc;
  logic [31:0]   fetchPcNext;
  logic [31:0]   targetPc;
  logic [31:0]   targetPcNext;
  logic [31:0]   redirectTarget;
  logic          push;
  logic          flush;
  logic          popReq;
  logic          headValid;
  logic [CW-1:0] count;
  fetchEntry_t   pushEntry;
  fetchEntry_t   headEntry;

  assign redirectTarget = alignPc(bus.redirect_pc);
  assign popReq         = bus.ir_ready && headValid;
  assign pushEntry      = '{pc: fetchPc, instr: bus.imem_rdata};

  // The request is held low while reset is asserted so the first request appears right after release.
  assign bus.imem_req  = reset && (state == FETCH || state == DRAIN);
  assign bus.imem_addr = fetchPc;
  assign bus.ir_valid  = headValid;
  assign bus.ir_out    = headEntry.instr;
  assign bus.ir_pc     = headEntry.pc;
  assign pc_out        = fetchPc;

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    stateNext    = state;
    fetchPcNext  = fetchPc;
    targetPcNext = targetPc;
    push         = 1'b0;
    flush        = 1'b0;
    case (state)
      FETCH: begin
        if (bus.redirect) begin
          flush = 1'b1;
          if (bus.imem_ack) begin
            fetchPcNext = redirectTarget;
          end else begin
            targetPcNext = redirectTarget;
            stateNext    = DRAIN;
          end
        end else if (bus.imem_ack) begin
          push        = 1'b1;
          fetchPcNext = fetchPc + PC_INC;
          if (count + CW'(1) - CW'(popReq) == CW'(DEPTH)) stateNext = STALL;
        end
      end
      DRAIN: begin
        // The outstanding request keeps its address; only the pending target moves.
        flush = bus.redirect;
        if (bus.imem_ack) begin
          fetchPcNext = bus.redirect ? redirectTarget : targetPc;
          stateNext   = FETCH;
        end else if (bus.redirect) begin
          targetPcNext = redirectTarget;
        end
      end
      STALL: begin
        if (bus.redirect) begin
          flush       = 1'b1;
          fetchPcNext = redirectTarget;
          stateNext   = FETCH;
        end else if (count < CW'(DEPTH)) begin
          stateNext = FETCH;
        end
      end
      default: stateNext = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= FETCH;
      fetchPc  <= RESET_PC;
      targetPc <= RESET_PC;
    end else begin
      state    <= stateNext;
      fetchPc  <= fetchPcNext;
      targetPc <= targetPcNext;
    end
  end

  mips_fetch_unit_fetch_buffer #(.DEPTH(DEPTH)) u_buffer (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pushEntry (pushEntry),
    .pop       (popReq),
    .flush     (flush),
    .headValid (headValid),
    .headEntry (headEntry),
    .count     (count)
  );

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Self-checking bench: vector table, directed redirect/reset sequences, randomized run against a queue model.
module tb_mips_fetch_unit;

  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_out;

  mips_fetch_unit_if bus();

  mips_fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk    (clk),
    .reset  (reset),
    .bus    (bus),
    .pc_out (pc_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  typedef struct packed {
    logic        rstn;
    logic        ack;
    logic [31:0] rdata;
    logic        ready;
    logic        expReq;
    logic [31:0] expAddr;
    logic        expValid;
    logic [31:0] expIr;
    logic [31:0] expIrPc;
  } rec_t;

  // Reference model: a queue of fetched words plus "waiting for old ack" and "buffer full" flags.
  ent_t        mq[$];
  logic [31:0] mPc;
  logic [31:0] mTarget;
  bit          mDrain;
  bit          mStall;

  logic        cRstn, cAck, cReady, cRedir;
  logic [31:0] cRdata, cRpc;

  function automatic logic [31:0] align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

  function automatic rec_t row(input logic rstn, input logic ack, input logic [31:0] rdata,
                               input logic ready, input logic expReq, input logic [31:0] expAddr,
                               input logic expValid, input logic [31:0] expIr, input logic [31:0] expIrPc);
    rec_t r;
    r.rstn = rstn;     r.ack = ack;       r.rdata = rdata;       r.ready = ready;
    r.expReq = expReq; r.expAddr = expAddr; r.expValid = expValid;
    r.expIr = expIr;   r.expIrPc = expIrPc;
    return r;
  endfunction

  task automatic check(input string name, input logic [129:0] act, input logic [129:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [129:0] observed();
    return {bus.imem_req, bus.imem_addr, bus.ir_valid, bus.ir_out, bus.ir_pc, pc_out};
  endfunction

  function automatic logic [129:0] modelOut();
    logic        v;
    logic [31:0] ir;
    logic [31:0] irPc;
    v    = (mq.size() != 0);
    ir   = v ? mq[0].instr : 32'h0;
    irPc = v ? mq[0].pc : 32'h0;
    return {cRstn && !mStall, mPc, v, ir, irPc, mPc};
  endfunction

  task automatic modelStep();
    bit   popped;
    ent_t e;
    if (!cRstn) begin
      mq.delete();
      mPc = RESET_PC; mTarget = RESET_PC; mDrain = 0; mStall = 0;
      return;
    end
    popped = cReady && (mq.size() != 0);
    if (mStall) begin
      if (cRedir) begin
        mq.delete(); mPc = align(cRpc); mStall = 0;
      end else begin
        if (mq.size() < DEPTH) mStall = 0;
        if (popped) void'(mq.pop_front());
      end
    end else if (mDrain) begin
      if (cRedir) mq.delete();
      else if (popped) void'(mq.pop_front());
      if (cAck) begin
        mPc = cRedir ? align(cRpc) : mTarget; mDrain = 0;
      end else if (cRedir) begin
        mTarget = align(cRpc);
      end
    end else begin
      if (cRedir) begin
        mq.delete();
        if (cAck) mPc = align(cRpc);
        else begin mTarget = align(cRpc); mDrain = 1; end
      end else begin
        if (popped) void'(mq.pop_front());
        if (cAck) begin
          e.pc = mPc; e.instr = cRdata;
          mq.push_back(e);
          mPc = mPc + 32'd4;
          if (mq.size() == DEPTH) mStall = 1;
        end
      end
    end
  endtask

  // Drive one cycle's inputs, let them settle, compare against the model.
  task automatic drive(input logic rstn, input logic ack, input logic [31:0] rdata, input logic ready,
                       input logic redir, input logic [31:0] rpc);
    cRstn = rstn; cAck = ack; cRdata = rdata; cReady = ready; cRedir = redir; cRpc = rpc;
    reset = rstn;
    bus.imem_ack = ack; bus.imem_rdata = rdata; bus.ir_ready = ready;
    bus.redirect = redir; bus.redirect_pc = rpc;
    #1;
    check("model", observed(), modelOut());
  endtask

  task automatic tick();
    modelStep();
    @(posedge clk);
    #1;
  endtask

  rec_t vec [16];

  initial begin
    vec[0]  = row(0, 0, 32'h0,         1, 0, 32'h0, 0, 32'h0,         32'h0);
    vec[1]  = row(1, 1, 32'hAAAA_0000, 1, 1, 32'h0, 0, 32'h0,         32'h0);
    vec[2]  = row(1, 1, 32'hAAAA_0004, 1, 1, 32'h4, 1, 32'hAAAA_0000, 32'h0);
    vec[3]  = row(1, 1, 32'hAAAA_0008, 1, 1, 32'h8, 1, 32'hAAAA_0004, 32'h4);
    vec[4]  = row(1, 0, 32'h0,         1, 1, 32'hC, 1, 32'hAAAA_0008, 32'h8);
    vec[5]  = row(1, 0, 32'h0,         0, 1, 32'hC, 0, 32'h0,         32'h0);
    vec[6]  = row(0, 0, 32'h0,         0, 0, 32'hC, 0, 32'h0,         32'h0);
    vec[7]  = row(0, 1, 32'hDEAD_0000, 0, 0, 32'h0, 0, 32'h0,         32'h0);
    vec[8]  = row(1, 1, 32'hB0,        0, 1, 32'h0, 0, 32'h0,         32'h0);
    vec[9]  = row(1, 1, 32'hB4,        0, 1, 32'h4, 1, 32'hB0,        32'h0);
    vec[10] = row(1, 1, 32'hEEEE,      0, 0, 32'h8, 1, 32'hB0,        32'h0);
    vec[11] = row(1, 0, 32'h0,         1, 0, 32'h8, 1, 32'hB0,        32'h0);
    vec[12] = row(1, 0, 32'h0,         0, 0, 32'h8, 1, 32'hB4,        32'h4);
    vec[13] = row(1, 0, 32'h0,         0, 1, 32'h8, 1, 32'hB4,        32'h4);
    vec[14] = row(1, 1, 32'hB8,        1, 1, 32'h8, 1, 32'hB4,        32'h4);
    vec[15] = row(1, 0, 32'h0,         1, 1, 32'hC, 1, 32'hB8,        32'h8);

    // Bring the design out of its unknown power-up state before anything is compared.
    cRstn = 0; cAck = 0; cRdata = 0; cReady = 0; cRedir = 0; cRpc = 0;
    reset = 0; bus.imem_ack = 0; bus.imem_rdata = 0; bus.ir_ready = 0;
    bus.redirect = 0; bus.redirect_pc = 0;
    #1;
    tick();

    for (int i = 0; i < 16; i++) begin
      drive(vec[i].rstn, vec[i].ack, vec[i].rdata, vec[i].ready, 1'b0, 32'h0);
      check($sformatf("vec%0d", i), observed(),
            {vec[i].expReq, vec[i].expAddr, vec[i].expValid, vec[i].expIr, vec[i].expIrPc, vec[i].expAddr});
      tick();
    end

    // Redirect while a request is outstanding: old address held, late word dropped.
    drive(1, 0, 32'h0, 1, 1, 32'h100);          tick();
    drive(1, 0, 32'h0, 1, 0, 32'h0);
    check("t3 hold addr", {97'h0, bus.imem_req, bus.imem_addr}, {97'h0, 1'b1, 32'hC});
    tick();
    drive(1, 0, 32'h0, 1, 0, 32'h0);            tick();
    drive(1, 1, 32'h5555, 1, 0, 32'h0);         tick();
    drive(1, 0, 32'h0, 1, 0, 32'h0);
    check("t3 new addr", {97'h0, bus.ir_valid, bus.imem_addr}, {97'h0, 1'b0, 32'h100});
    tick();

    // Redirect coinciding with an ack flushes a buffered word and drops the new one.
    drive(1, 1, 32'h6666, 0, 0, 32'h0);         tick();
    drive(1, 1, 32'h7777, 0, 1, 32'h200);       tick();
    drive(1, 0, 32'h0, 0, 0, 32'h0);
    check("t4 flush", {97'h0, bus.ir_valid, bus.imem_addr}, {97'h0, 1'b0, 32'h200});
    tick();

    // Top-of-memory wrap and redirect alignment.
    drive(1, 1, 32'h0, 0, 1, 32'hFFFF_FFFC);    tick();
    drive(1, 1, 32'hC0, 0, 0, 32'h0);
    check("t5 top addr", {98'h0, bus.imem_addr}, {98'h0, 32'hFFFF_FFFC});
    tick();
    drive(1, 0, 32'h0, 0, 0, 32'h0);
    check("t5 wrap", {66'h0, bus.imem_addr, bus.ir_pc}, {66'h0, 32'h0, 32'hFFFF_FFFC});
    tick();
    drive(1, 1, 32'h0, 0, 1, 32'h103);          tick();
    drive(1, 0, 32'h0, 0, 0, 32'h0);
    check("t5 align", {97'h0, bus.ir_valid, bus.imem_addr}, {97'h0, 1'b0, 32'h100});
    tick();

    // Reset during an outstanding request, stray ack while reset is still low.
    drive(0, 0, 32'h0, 1, 0, 32'h0);            tick();
    drive(0, 1, 32'hBAD0, 1, 0, 32'h0);         tick();
    drive(1, 0, 32'h0, 1, 0, 32'h0);
    check("t6 reset", {96'h0, bus.imem_req, bus.ir_valid, bus.imem_addr}, {96'h0, 1'b1, 1'b0, RESET_PC});
    tick();
    drive(1, 0, 32'h0, 1, 0, 32'h0);
    check("t6 no push", {129'h0, bus.ir_valid}, 130'h0);
    tick();

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      drive($urandom_range(0, 199) != 0, $urandom_range(0, 3) != 0, $urandom,
            $urandom_range(0, 2) != 0, $urandom_range(0, 9) == 0, $urandom);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
